operand_collector: RTL and testbench
====================================

Name: operand_collector

Overview:
- Parametrised successor to the per-PE compute-stall logic.
- Decides per-source operand readiness for NUM_SRC sources across the INTERIM, NEIGHBOR, BUS and BRAM namespaces.
- Latches pulse-valid operands that arrive early, and fires the instruction once all required operands are present.
- Pops the shared neighbor/bus data registers on fire, and tracks stall duration with a sticky hang flag.
- Sits between the PE instruction decoder and the ALU.

Parameters:
NUM_SRC, 3, number of source operands per instruction
INDEX_LEN, 8, width of each source index field
DATA_W, 16, operand data width
CNT_W, 8, stall counter width
TIMEOUT, 200, consecutive stall cycles that set hang; 0 disables

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_valid  in  1  decoded instruction present; held until inst_fire
src_ns  in  3*NUM_SRC  per-source namespace code: 0 NONE, 1 BRAM, 2 INTERIM, 3 NEIGHBOR, 4 BUS; 5-7 treated as NONE
src_index  in  INDEX_LEN*NUM_SRC  per-source index; bit0 selects PE(0)/PU-or-GB(1) for NEIGHBOR/BUS
bram_data  in  DATA_W*NUM_SRC  per-source BRAM read data
bram_v  in  NUM_SRC  per-source one-cycle BRAM read valid pulse
interim_data, interim_v  in  DATA_W, 1  ALU writeback bypass; one-cycle pulse
pe_neigh_data, pe_neigh_v  in  DATA_W, 1  held register, cleared by pop
pu_neigh_data, pu_neigh_v  in  DATA_W, 1  held register
pe_bus_data, pe_bus_v  in  DATA_W, 1  held register
gb_bus_data, gb_bus_v  in  DATA_W, 1  held register
src_data  out  DATA_W*NUM_SRC  operand values presented to ALU
src_v  out  NUM_SRC  per-source ready
inst_fire  out  1  all operands ready; instruction issues this cycle
inst_stall  out  1  inst_valid && !inst_fire
pe_neigh_pop, pu_neigh_pop, pe_bus_pop, gb_bus_pop  out  1 each  single-cycle pop to held registers
stall_cnt  out  CNT_W  consecutive stall cycles, saturating
hang  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - all capture flags and capture registers 0
  - stall_cnt 0, hang 0
  - state IDLE
  - all combinational outputs follow the reset state (pops 0, inst_fire 0).
- Live valid for source i (live_v[i]):
  - NONE: 0
  - BRAM: bram_v[i]
  - INTERIM: interim_v
  - NEIGHBOR: index bit0 ? pu_neigh_v : pe_neigh_v
  - BUS: index bit0 ? gb_bus_v : pe_bus_v
- Capture:
  - BRAM and INTERIM are pulse sources.
  - When inst_valid && live_v[i] && !cap[i] && !inst_fire, for ns in {BRAM, INTERIM}: cap[i]<=1, capreg[i]<=live data at the next edge.
  - NEIGHBOR and BUS sources are never captured; they are read live (registers hold until popped).
- Readiness and outputs:
  - src_v[i] = inst_valid && (ns==NONE || cap[i] || live_v[i]).
  - src_data[i] = cap[i] ? capreg[i] : live data; 0 for NONE.
  - inst_fire = inst_valid && &src_v. Zero-latency: fire is combinational in the cycle the last operand arrives.
- Pops:
  - On inst_fire, each held-register pop is asserted for exactly one cycle if any source references that register.
  - The pop is asserted once even if multiple sources reference the same register.
  - No pop is asserted without fire.
- Fire/withdraw: on inst_fire, all cap cleared at the next edge. If inst_valid drops without fire, all cap cleared and stall_cnt cleared.
- State machine:
  - IDLE: no captures, no inst. Goes to WAIT on inst_valid && !inst_fire.
  - WAIT: returns to IDLE on inst_fire or !inst_valid. Goes to HANG when TIMEOUT!=0 and stall_cnt reaches TIMEOUT-1 while still stalling.
  - HANG: behaves as WAIT, with hang=1 and sticky; only reset clears it.
- stall_cnt: increments each inst_stall cycle, saturating at 2^CNT_W-1, and clears to 0 on fire.
- Simultaneous events:
  - A capture and a fire in the same cycle: fire wins and no capture is stored.
  - A held register whose valid rises in the same cycle as a pulse operand: both count as ready.
- Reset mid-WAIT discards captures and performs no pops.

Test Plan:
- All three sources NEIGHBOR idx0, pe_neigh_v=1 with inst_valid -> inst_fire in the same cycle, pe_neigh_pop=1 for exactly one cycle, other pops 0, stall_cnt 0.
- src0 BRAM pulse at t=0 (data 0x1234), src1 BUS idx1 with gb_bus_v rising at t=3, src2 NONE:
  - inst_stall for t=0..2 and stall_cnt reaches 3
  - fire at t=3 with src_data0=0x1234 (captured) and gb_bus_pop=1.
- src0 and src1 INTERIM, interim_v pulse at t=1 (0x00AA), src2 NEIGHBOR idx1 valid at t=4 -> fire at t=4, both src_data0 and src_data1 = 0x00AA.
- TIMEOUT=5, required BUS operand never valid:
  - hang rises after 5 stall cycles; stall_cnt continues to 2^CNT_W-1 and holds there
  - hang stays 1 after operand arrives and fire occurs; cleared only by reset.
- BRAM captured at t=0, inst_valid dropped at t=2, reasserted t=3 with no new bram_v -> no fire, cap cleared, stall_cnt restarts from 0.
- reset asserted during WAIT with captures -> next cycle all caps 0, stall_cnt 0, no pops, state IDLE.

Source files
------------

// File: rtl/operand_collector_if.sv
// -----------------------------------------------------------------------------
// operand_collector_if
// Purpose : Bundles the decoder-side request, the operand sources and the
//           ALU-side results of the operand collector.
// Modports:
//   master - instruction decoder / operand sources (drives requests and data)
//   slave  - operand_collector (drives readiness, data to ALU, pops, status)
// Signals :
//   inst_valid, src_ns, src_index            decoded instruction
//   bram_data/bram_v, interim_data/_v        pulse-valid operand sources
//   {pe,pu}_neigh_*, {pe,gb}_bus_*           held operand registers
//   src_data, src_v, inst_fire, inst_stall   collector results
//   *_pop, stall_cnt, hang                   pops and stall tracking
// -----------------------------------------------------------------------------
interface operand_collector_if #(
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned INDEX_LEN = 8,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CNT_W     = 8
);
    logic                           inst_valid;
    logic [3*NUM_SRC-1:0]           src_ns;
    logic [INDEX_LEN*NUM_SRC-1:0]   src_index;
    logic [DATA_W*NUM_SRC-1:0]      bram_data;
    logic [NUM_SRC-1:0]             bram_v;
    logic [DATA_W-1:0]              interim_data;
    logic                           interim_v;
    logic [DATA_W-1:0]              pe_neigh_data;
    logic                           pe_neigh_v;
    logic [DATA_W-1:0]              pu_neigh_data;
    logic                           pu_neigh_v;
    logic [DATA_W-1:0]              pe_bus_data;
    logic                           pe_bus_v;
    logic [DATA_W-1:0]              gb_bus_data;
    logic                           gb_bus_v;

    logic [DATA_W*NUM_SRC-1:0]      src_data;
    logic [NUM_SRC-1:0]             src_v;
    logic                           inst_fire;
    logic                           inst_stall;
    logic                           pe_neigh_pop;
    logic                           pu_neigh_pop;
    logic                           pe_bus_pop;
    logic                           gb_bus_pop;
    logic [CNT_W-1:0]               stall_cnt;
    logic                           hang;

    modport master (
        output inst_valid, src_ns, src_index, bram_data, bram_v,
               interim_data, interim_v, pe_neigh_data, pe_neigh_v,
               pu_neigh_data, pu_neigh_v, pe_bus_data, pe_bus_v,
               gb_bus_data, gb_bus_v,
        input  src_data, src_v, inst_fire, inst_stall, pe_neigh_pop,
               pu_neigh_pop, pe_bus_pop, gb_bus_pop, stall_cnt, hang
    );

    modport slave (
        input  inst_valid, src_ns, src_index, bram_data, bram_v,
               interim_data, interim_v, pe_neigh_data, pe_neigh_v,
               pu_neigh_data, pu_neigh_v, pe_bus_data, pe_bus_v,
               gb_bus_data, gb_bus_v,
        output src_data, src_v, inst_fire, inst_stall, pe_neigh_pop,
               pu_neigh_pop, pe_bus_pop, gb_bus_pop, stall_cnt, hang
    );
endinterface

// File: rtl/operand_collector.sv
// -----------------------------------------------------------------------------
// operand_collector
// Purpose : Per-PE operand readiness between decoder and ALU. Latches early
//           pulse-valid operands (BRAM, INTERIM), reads held registers
//           (NEIGHBOR, BUS) live, fires the instruction in the cycle the last
//           operand is present, pops referenced held registers on fire and
//           tracks stall duration with a sticky hang flag.
// Ports   :
//   clk    - clock
//   reset  - synchronous active-high reset
//   io     - operand_collector_if.slave (decoder, sources, ALU side)
// -----------------------------------------------------------------------------
module operand_collector #(
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned INDEX_LEN = 8,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TIMEOUT   = 200
) (
    input  logic               clk,
    input  logic               reset,
    operand_collector_if.slave io
);
    localparam int unsigned NS_W = 3;
    localparam logic [NS_W-1:0] NS_BRAM     = 3'd1;
    localparam logic [NS_W-1:0] NS_INTERIM  = 3'd2;
    localparam logic [NS_W-1:0] NS_NEIGHBOR = 3'd3;
    localparam logic [NS_W-1:0] NS_BUS      = 3'd4;
    localparam int unsigned TIMEOUT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HANG = 2'd2
    } state_e;

    state_e             state_q, state_d;

    logic [NUM_SRC-1:0] live_v;
    logic [NUM_SRC-1:0] pulse_ns;
    logic [NUM_SRC-1:0] none_ns;
    logic [DATA_W-1:0]  live_data [NUM_SRC];
    logic [NUM_SRC-1:0] src_v_c;

    logic [NUM_SRC-1:0] cap_q, cap_d;
    logic [DATA_W-1:0]  capreg_q [NUM_SRC];
    logic [DATA_W-1:0]  capreg_d [NUM_SRC];
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic ref_pe_neigh, ref_pu_neigh, ref_pe_bus, ref_gb_bus;
    logic inst_fire_c, inst_stall_c, hang_hit_c, hang_c;

    // Namespace decode: live valid/data per source and held-register references.
    always_comb begin
        live_v       = '0;
        pulse_ns     = '0;
        none_ns      = '0;
        ref_pe_neigh = 1'b0;
        ref_pu_neigh = 1'b0;
        ref_pe_bus   = 1'b0;
        ref_gb_bus   = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            live_data[i] = '0;
            case (io.src_ns[i*NS_W +: NS_W])
                NS_BRAM: begin
                    pulse_ns[i]  = 1'b1;
                    live_v[i]    = io.bram_v[i];
                    live_data[i] = io.bram_data[i*DATA_W +: DATA_W];
                end
                NS_INTERIM: begin
                    pulse_ns[i]  = 1'b1;
                    live_v[i]    = io.interim_v;
                    live_data[i] = io.interim_data;
                end
                NS_NEIGHBOR: begin
                    if (io.src_index[i*INDEX_LEN]) begin
                        live_v[i]    = io.pu_neigh_v;
                        live_data[i] = io.pu_neigh_data;
                        ref_pu_neigh = 1'b1;
                    end else begin
                        live_v[i]    = io.pe_neigh_v;
                        live_data[i] = io.pe_neigh_data;
                        ref_pe_neigh = 1'b1;
                    end
                end
                NS_BUS: begin
                    if (io.src_index[i*INDEX_LEN]) begin
                        live_v[i]    = io.gb_bus_v;
                        live_data[i] = io.gb_bus_data;
                        ref_gb_bus   = 1'b1;
                    end else begin
                        live_v[i]    = io.pe_bus_v;
                        live_data[i] = io.pe_bus_data;
                        ref_pe_bus   = 1'b1;
                    end
                end
                // Codes 0 and 5-7 need no operand.
                default: none_ns[i] = 1'b1;
            endcase
        end
    end

    // Readiness and operand mux: captured value wins over the live source.
    always_comb begin
        src_v_c     = '0;
        io.src_data = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src_v_c[i] = io.inst_valid && (none_ns[i] || cap_q[i] || live_v[i]);
            io.src_data[i*DATA_W +: DATA_W] = cap_q[i] ? capreg_q[i] : live_data[i];
        end
    end

    assign inst_fire_c  = io.inst_valid && (&src_v_c);
    assign inst_stall_c = io.inst_valid && !inst_fire_c;

    assign io.src_v        = src_v_c;
    assign io.inst_fire    = inst_fire_c;
    assign io.inst_stall   = inst_stall_c;
    assign io.pe_neigh_pop = inst_fire_c && ref_pe_neigh;
    assign io.pu_neigh_pop = inst_fire_c && ref_pu_neigh;
    assign io.pe_bus_pop   = inst_fire_c && ref_pe_bus;
    assign io.gb_bus_pop   = inst_fire_c && ref_gb_bus;
    assign io.stall_cnt    = stall_cnt_q;
    assign io.hang         = hang_c;

    // Capture next-state: fire or withdraw flushes; otherwise latch new pulses.
    always_comb begin
        cap_d    = cap_q;
        capreg_d = capreg_q;
        if (!io.inst_valid || inst_fire_c) begin
            cap_d = '0;
        end else begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (pulse_ns[i] && live_v[i] && !cap_q[i]) begin
                    cap_d[i]    = 1'b1;
                    capreg_d[i] = live_data[i];
                end
            end
        end
    end

    // Any non-stall cycle (fire or withdraw) restarts the count; saturates.
    assign stall_cnt_d = !inst_stall_c     ? '0 :
                         (&stall_cnt_q)    ? stall_cnt_q :
                                             stall_cnt_q + CNT_W'(1);

    assign hang_hit_c = (TIMEOUT != 0) && inst_stall_c &&
                        (32'(stall_cnt_q) >= TIMEOUT_LAST);

    // Capture and stall-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q       <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                capreg_q[i] <= '0;
            end
        end else begin
            cap_q       <= cap_d;
            stall_cnt_q <= stall_cnt_d;
            capreg_q    <= capreg_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; HANG is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hang_hit_c) begin
                    state_d = ST_HANG;
                end else if (inst_stall_c) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (hang_hit_c) begin
                    state_d = ST_HANG;
                end else if (inst_fire_c || !io.inst_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HANG: state_d = ST_HANG;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        hang_c = 1'b0;
        if (state_q == ST_HANG) begin
            hang_c = 1'b1;
        end
    end
endmodule

// File: tb/tb_operand_collector.sv
// -----------------------------------------------------------------------------
// tb_operand_collector
// Purpose : Directed, table-driven bench for operand_collector (TIMEOUT=5)
//           plus hand-written hang and mid-wait reset sequences.
// -----------------------------------------------------------------------------
module tb_operand_collector;
    localparam int unsigned NUM_SRC   = 3;
    localparam int unsigned INDEX_LEN = 8;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned CNT_W     = 8;

    localparam logic [15:0] PE_NEIGH_D = 16'h1111;
    localparam logic [15:0] PU_NEIGH_D = 16'h2222;
    localparam logic [15:0] PE_BUS_D   = 16'h3333;
    localparam logic [15:0] GB_BUS_D   = 16'h4444;

    logic clk;
    logic reset;

    operand_collector_if #(
        .NUM_SRC(NUM_SRC), .INDEX_LEN(INDEX_LEN), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) bus ();

    operand_collector #(
        .NUM_SRC(NUM_SRC), .INDEX_LEN(INDEX_LEN), .DATA_W(DATA_W),
        .CNT_W(CNT_W), .TIMEOUT(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // held_v / pops order: {pe_neigh, pu_neigh, pe_bus, gb_bus}
    typedef struct {
        logic        valid;
        logic [8:0]  ns;
        logic [23:0] idx;
        logic [2:0]  bram_v;
        logic [47:0] bram_data;
        logic        interim_v;
        logic [15:0] interim_data;
        logic [3:0]  held_v;
        logic [2:0]  e_src_v;
        logic        e_fire;
        logic        e_stall;
        logic [3:0]  e_pops;
        logic [47:0] e_data;
        logic [7:0]  e_cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vq[$];

    function automatic vec_t mk(
        input logic v, input logic [8:0] ns, input logic [23:0] idx,
        input logic [2:0] bv, input logic [47:0] bd,
        input logic iv, input logic [15:0] id, input logic [3:0] hv,
        input logic [2:0] esv, input logic ef, input logic es,
        input logic [3:0] ep, input logic [47:0] ed, input logic [7:0] ec);
        vec_t r;
        r.valid = v;  r.ns = ns;  r.idx = idx;  r.bram_v = bv;  r.bram_data = bd;
        r.interim_v = iv;  r.interim_data = id;  r.held_v = hv;
        r.e_src_v = esv;  r.e_fire = ef;  r.e_stall = es;  r.e_pops = ep;
        r.e_data = ed;  r.e_cnt = ec;
        return r;
    endfunction

    function automatic vec_t idle(input logic [7:0] cnt);
        return mk(1'b0, 9'o000, 24'h0, 3'b000, 48'h0, 1'b0, 16'h0, 4'b0000,
                  3'b000, 1'b0, 1'b0, 4'b0000, 48'h0, cnt);
    endfunction

    task automatic apply(input vec_t v);
        bus.inst_valid   = v.valid;
        bus.src_ns       = v.ns;
        bus.src_index    = v.idx;
        bus.bram_v       = v.bram_v;
        bus.bram_data    = v.bram_data;
        bus.interim_v    = v.interim_v;
        bus.interim_data = v.interim_data;
        bus.pe_neigh_v   = v.held_v[3];
        bus.pu_neigh_v   = v.held_v[2];
        bus.pe_bus_v     = v.held_v[1];
        bus.gb_bus_v     = v.held_v[0];
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] pops();
        return {bus.pe_neigh_pop, bus.pu_neigh_pop, bus.pe_bus_pop, bus.gb_bus_pop};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.pe_neigh_data = PE_NEIGH_D;
        bus.pu_neigh_data = PU_NEIGH_D;
        bus.pe_bus_data   = PE_BUS_D;
        bus.gb_bus_data   = GB_BUS_D;
        apply(idle(8'd0));
        reset = 1'b1;

        // Vector table (one entry per cycle).
        vq.push_back(idle(8'd0));
        // All NEIGHBOR idx0, held valid: same-cycle fire, single pe_neigh pop.
        vq.push_back(mk(1, 9'o333, 24'h0, 3'b000, 48'h0, 0, 16'h0, 4'b1000,
                        3'b111, 1, 0, 4'b1000, 48'h1111_1111_1111, 8'd0));
        vq.push_back(idle(8'd0));
        // BRAM pulse captured at t0, gb_bus arrives t3.
        vq.push_back(mk(1, 9'o041, 24'h000100, 3'b001, 48'h0000_0000_1234, 0, 16'h0, 4'b0000,
                        3'b101, 0, 1, 4'b0000, 48'h0000_4444_1234, 8'd0));
        vq.push_back(mk(1, 9'o041, 24'h000100, 3'b000, 48'h0000_0000_DEAD, 0, 16'h0, 4'b0000,
                        3'b101, 0, 1, 4'b0000, 48'h0000_4444_1234, 8'd1));
        vq.push_back(mk(1, 9'o041, 24'h000100, 3'b000, 48'h0000_0000_DEAD, 0, 16'h0, 4'b0000,
                        3'b101, 0, 1, 4'b0000, 48'h0000_4444_1234, 8'd2));
        vq.push_back(mk(1, 9'o041, 24'h000100, 3'b000, 48'h0000_0000_DEAD, 0, 16'h0, 4'b0001,
                        3'b111, 1, 0, 4'b0001, 48'h0000_4444_1234, 8'd3));
        vq.push_back(idle(8'd0));
        // Two INTERIM sources share one pulse at t1; pu_neigh arrives t4.
        vq.push_back(mk(1, 9'o322, 24'h010000, 3'b000, 48'h0, 0, 16'h0000, 4'b0000,
                        3'b000, 0, 1, 4'b0000, 48'h2222_0000_0000, 8'd0));
        vq.push_back(mk(1, 9'o322, 24'h010000, 3'b000, 48'h0, 1, 16'h00AA, 4'b0000,
                        3'b011, 0, 1, 4'b0000, 48'h2222_00AA_00AA, 8'd1));
        vq.push_back(mk(1, 9'o322, 24'h010000, 3'b000, 48'h0, 0, 16'h0BAD, 4'b0000,
                        3'b011, 0, 1, 4'b0000, 48'h2222_00AA_00AA, 8'd2));
        vq.push_back(mk(1, 9'o322, 24'h010000, 3'b000, 48'h0, 0, 16'h0BAD, 4'b0000,
                        3'b011, 0, 1, 4'b0000, 48'h2222_00AA_00AA, 8'd3));
        vq.push_back(mk(1, 9'o322, 24'h010000, 3'b000, 48'h0, 0, 16'h0BAD, 4'b0100,
                        3'b111, 1, 0, 4'b0100, 48'h2222_00AA_00AA, 8'd4));
        vq.push_back(idle(8'd0));
        // Pulse and held valids together: fire, two pops, pulse not captured.
        vq.push_back(mk(1, 9'o341, 24'h0, 3'b001, 48'h0000_0000_5555, 0, 16'h0, 4'b1010,
                        3'b111, 1, 0, 4'b1010, 48'h1111_3333_5555, 8'd0));
        vq.push_back(mk(1, 9'o341, 24'h0, 3'b000, 48'h0, 0, 16'h0, 4'b0000,
                        3'b000, 0, 1, 4'b0000, 48'h1111_3333_0000, 8'd0));
        vq.push_back(idle(8'd1));
        // Withdraw after capture: capture and count are discarded.
        vq.push_back(mk(1, 9'o041, 24'h000100, 3'b001, 48'h0000_0000_7777, 0, 16'h0, 4'b0000,
                        3'b101, 0, 1, 4'b0000, 48'h0000_4444_7777, 8'd0));
        vq.push_back(mk(1, 9'o041, 24'h000100, 3'b000, 48'h0, 0, 16'h0, 4'b0000,
                        3'b101, 0, 1, 4'b0000, 48'h0000_4444_7777, 8'd1));
        vq.push_back(mk(0, 9'o041, 24'h000100, 3'b000, 48'h0, 0, 16'h0, 4'b0000,
                        3'b000, 0, 0, 4'b0000, 48'h0000_4444_7777, 8'd2));
        vq.push_back(mk(1, 9'o041, 24'h000100, 3'b000, 48'h0, 0, 16'h0, 4'b0000,
                        3'b100, 0, 1, 4'b0000, 48'h0000_4444_0000, 8'd0));
        vq.push_back(idle(8'd1));
        vq.push_back(idle(8'd0));

        next_cycle();
        next_cycle();
        reset = 1'b0;

        foreach (vq[k]) begin
            apply(vq[k]);
            @(negedge clk);
            chk($sformatf("v%0d src_v", k),      64'(bus.src_v),      64'(vq[k].e_src_v));
            chk($sformatf("v%0d inst_fire", k),  64'(bus.inst_fire),  64'(vq[k].e_fire));
            chk($sformatf("v%0d inst_stall", k), 64'(bus.inst_stall), 64'(vq[k].e_stall));
            chk($sformatf("v%0d pops", k),       64'(pops()),         64'(vq[k].e_pops));
            chk($sformatf("v%0d src_data", k),   64'(bus.src_data),   64'(vq[k].e_data));
            chk($sformatf("v%0d stall_cnt", k),  64'(bus.stall_cnt),  64'(vq[k].e_cnt));
            chk($sformatf("v%0d hang", k),       64'(bus.hang),       64'd0);
            next_cycle();
        end

        // Hang: gb_bus operand never valid; hang after 5 stalls, count saturates.
        apply(mk(1, 9'o004, 24'h000001, 3'b000, 48'h0, 0, 16'h0, 4'b0000,
                 3'b000, 0, 0, 4'b0000, 48'h0, 8'd0));
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            chk($sformatf("hang c%0d stall_cnt", k), 64'(bus.stall_cnt), 64'((k > 255) ? 255 : k));
            chk($sformatf("hang c%0d hang", k),      64'(bus.hang),       64'(k >= 5));
            chk($sformatf("hang c%0d stall", k),     64'(bus.inst_stall), 64'd1);
            next_cycle();
        end
        bus.gb_bus_v = 1'b1;
        @(negedge clk);
        chk("hang arrive fire", 64'(bus.inst_fire), 64'd1);
        chk("hang arrive pops", 64'(pops()),        64'h1);
        chk("hang arrive hang", 64'(bus.hang),      64'd1);
        chk("hang arrive cnt",  64'(bus.stall_cnt), 64'd255);
        next_cycle();
        apply(idle(8'd0));
        @(negedge clk);
        chk("hang sticky hang", 64'(bus.hang),      64'd1);
        chk("hang sticky cnt",  64'(bus.stall_cnt), 64'd0);
        chk("hang sticky pops", 64'(pops()),        64'h0);
        next_cycle();

        // Reset in WAIT with a captured BRAM operand.
        apply(mk(1, 9'o041, 24'h000100, 3'b001, 48'h0000_0000_9999, 0, 16'h0, 4'b0000,
                 3'b000, 0, 0, 4'b0000, 48'h0, 8'd0));
        @(negedge clk);
        chk("rst pre src_v", 64'(bus.src_v), 64'b101);
        next_cycle();
        bus.bram_v    = 3'b000;
        bus.bram_data = 48'h0;
        @(negedge clk);
        chk("rst pre captured", 64'(bus.src_data[15:0]), 64'h9999);
        chk("rst pre cnt",      64'(bus.stall_cnt),       64'd1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst during pops", 64'(pops()),        64'h0);
        chk("rst during fire", 64'(bus.inst_fire), 64'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst post src_v", 64'(bus.src_v),           64'b100);
        chk("rst post data0", 64'(bus.src_data[15:0]),  64'h0);
        chk("rst post cnt",   64'(bus.stall_cnt),       64'd0);
        chk("rst post hang",  64'(bus.hang),            64'd0);
        chk("rst post pops",  64'(pops()),              64'h0);
        next_cycle();
        apply(idle(8'd0));
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
